regfile_write_buffer: RTL and testbench

//  Write-side buffer in front of the 32x32 register file's single write port.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_fifo.sv | 128 ++++++++++++
 rtl/regfile_write_buffer.sv | 87 ++++++++
 tb/tb_regfile_write_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the buffered-writeback entry type.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Entry storage for the regfile write buffer: FIFO pointers, occupancy, kill-by-address
// and youngest-live-match lookup (lookup built only when REGFILE_WB_BYPASS_EN is defined).
module regfile_wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_addr_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [ADDR_W-1:0]        kill_addr_i,
    input  logic [ADDR_W-1:0]        lookup_addr1_i,
    input  logic [ADDR_W-1:0]        lookup_addr2_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     head_live_o,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     hit1_o,
    output logic [DATA_W-1:0]        data1_o,
    output logic                     hit2_o,
    output logic [DATA_W-1:0]        data2_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  live_q, live_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_live_o = live_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

    // Kill is applied before the push so an entry written on the killing edge survives.
    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (kill_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == kill_addr_i) live_d[i] = 1'b0;
            end
        end
        if (pop_i) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            live_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q] = push_addr_i;
            data_d[wr_ptr_q] = push_data_i;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        hit1_o  = 1'b0;
        data1_o = '0;
        hit2_o  = 1'b0;
        data2_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && live_q[idx]) begin
                if ((lookup_addr1_i != '0) && (addr_q[idx] == lookup_addr1_i)) begin
                    hit1_o  = 1'b1;
                    data1_o = data_q[idx];
                end
                if ((lookup_addr2_i != '0) && (addr_q[idx] == lookup_addr2_i)) begin
                    hit2_o  = 1'b1;
                    data2_o = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_addr1_i, lookup_addr2_i};
    assign hit1_o  = 1'b0;
    assign data1_o = '0;
    assign hit2_o  = 1'b0;
    assign data2_o = '0;
`endif

endmodule

// File: rtl/regfile_write_buffer.sv
// Write-side buffer merging pipeline writeback with queued long-latency writes.
// Optional decode bypass of pending entries: define REGFILE_WB_BYPASS_EN.
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   PipeRegWrite,
    input  logic [ADDR_W-1:0]      PipeWriteRegister,
    input  logic [DATA_W-1:0]      PipeWriteData,
    input  logic                   EnqValid,
    output logic                   EnqReady,
    input  logic [ADDR_W-1:0]      EnqRegister,
    input  logic [DATA_W-1:0]      EnqData,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      WriteRegister,
    output logic [DATA_W-1:0]      WriteData,
    input  logic [ADDR_W-1:0]      LookupRegister1,
    input  logic [ADDR_W-1:0]      LookupRegister2,
    output logic                   LookupHit1,
    output logic                   LookupHit2,
    output logic [DATA_W-1:0]      LookupData1,
    output logic [DATA_W-1:0]      LookupData2,
    output logic [$clog2(DEPTH):0] Count
);

    logic              full, empty, push, pop, kill;
    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              reg_write_d;

    assign EnqReady = !full;
    // $0 requests complete the handshake but are never stored.
    assign push = EnqValid && !full && (EnqRegister != ADDR_W'(ZERO_REG));
    assign pop  = !PipeRegWrite && !empty;
    assign kill = PipeRegWrite && (PipeWriteRegister != ADDR_W'(ZERO_REG));

    regfile_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i          (Clk),
        .rst_ni         (Rst_n),
        .push_i         (push),
        .push_addr_i    (EnqRegister),
        .push_data_i    (EnqData),
        .pop_i          (pop),
        .kill_i         (kill),
        .kill_addr_i    (PipeWriteRegister),
        .lookup_addr1_i (LookupRegister1),
        .lookup_addr2_i (LookupRegister2),
        .full_o         (full),
        .empty_o        (empty),
        .head_live_o    (head_live),
        .head_addr_o    (head_addr),
        .head_data_o    (head_data),
        .count_o        (Count),
        .hit1_o         (LookupHit1),
        .data1_o        (LookupData1),
        .hit2_o         (LookupHit2),
        .data2_o        (LookupData2)
    );

    always_comb begin
        reg_write_d   = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        if (PipeRegWrite) begin
            reg_write_d   = 1'b1;
            WriteRegister = PipeWriteRegister;
            WriteData     = PipeWriteData;
        end else if (!empty && head_live) begin
            reg_write_d   = 1'b1;
            WriteRegister = head_addr;
            WriteData     = head_data;
        end
    end

    assign RegWrite = reg_write_d && Rst_n;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: vector table plus corner-case sequences.
module tb_regfile_write_buffer;
    import regfile_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        PipeRegWrite;
    logic [4:0]  PipeWriteRegister;
    logic [31:0] PipeWriteData;
    logic        EnqValid;
    logic        EnqReady;
    logic [4:0]  EnqRegister;
    logic [31:0] EnqData;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  LookupRegister1, LookupRegister2;
    logic        LookupHit1, LookupHit2;
    logic [31:0] LookupData1, LookupData2;
    logic [2:0]  Count;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    logic [31:0] rf [32];

    always #5 Clk = ~Clk;

    regfile_write_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .PipeRegWrite      (PipeRegWrite),
        .PipeWriteRegister (PipeWriteRegister),
        .PipeWriteData     (PipeWriteData),
        .EnqValid          (EnqValid),
        .EnqReady          (EnqReady),
        .EnqRegister       (EnqRegister),
        .EnqData           (EnqData),
        .RegWrite          (RegWrite),
        .WriteRegister     (WriteRegister),
        .WriteData         (WriteData),
        .LookupRegister1   (LookupRegister1),
        .LookupRegister2   (LookupRegister2),
        .LookupHit1        (LookupHit1),
        .LookupHit2        (LookupHit2),
        .LookupData1       (LookupData1),
        .LookupData2       (LookupData2),
        .Count             (Count)
    );

    // Register file behind the write port; $0 is hardwired to zero.
    always @(posedge Clk) begin
        if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
    end

    typedef struct {
        wb_entry_t   enq;
        logic        pipe_we;
        logic [4:0]  pipe_reg;
        logic [31:0] pipe_data;
        logic        exp_rw;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
        logic [2:0]  exp_cnt;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mkv(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                                 input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                                 input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [2:0] c, input logic rdy);
        vec_t v;
        v.enq.live = ev;   v.enq.addr = er;  v.enq.data = ed;
        v.pipe_we  = pw;   v.pipe_reg = pr;  v.pipe_data = pd;
        v.exp_rw   = rw;   v.exp_wr   = wr;  v.exp_wd    = wd;
        v.exp_cnt  = c;    v.exp_rdy  = rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                         input logic pw, input logic [4:0] pr, input logic [31:0] pd);
        @(negedge Clk);
        EnqValid = ev; EnqRegister = er; EnqData = ed;
        PipeRegWrite = pw; PipeWriteRegister = pr; PipeWriteData = pd;
        #1;
    endtask

    task automatic chk_port(input string nm, input logic rw, input logic [4:0] wr,
                            input logic [31:0] wd, input logic [2:0] c);
        chk({nm, "_rw"}, RegWrite, rw);
        if (rw) begin
            chk({nm, "_wr"}, WriteRegister, wr);
            chk({nm, "_wd"}, WriteData, wd);
        end
        chk({nm, "_cnt"}, Count, c);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        Rst_n = 1'b0;
        PipeRegWrite = 1'b1; PipeWriteRegister = 5'd9; PipeWriteData = 32'h9;
        EnqValid = 1'b0; EnqRegister = '0; EnqData = '0;
        LookupRegister1 = '0; LookupRegister2 = '0;

        tbl[0]  = mkv(1,  5, 32'hA5,   0, 0, 0,         0,  0, 0,         0, 1);
        tbl[1]  = mkv(0,  0, 0,        0, 0, 0,         1,  5, 32'hA5,    1, 1);
        tbl[2]  = mkv(0,  0, 0,        0, 0, 0,         0,  0, 0,         0, 1);
        tbl[3]  = mkv(1,  0, 32'hFF,   0, 0, 0,         0,  0, 0,         0, 1);
        tbl[4]  = mkv(0,  0, 0,        0, 0, 0,         0,  0, 0,         0, 1);
        tbl[5]  = mkv(1, 10, 32'h10,   1, 1, 32'h1000,  1,  1, 32'h1000,  0, 1);
        tbl[6]  = mkv(1, 11, 32'h11,   1, 2, 32'h2000,  1,  2, 32'h2000,  1, 1);
        tbl[7]  = mkv(1, 12, 32'h12,   1, 1, 32'h3000,  1,  1, 32'h3000,  2, 1);
        tbl[8]  = mkv(1, 13, 32'h13,   1, 2, 32'h4000,  1,  2, 32'h4000,  3, 1);
        tbl[9]  = mkv(1, 14, 32'h14,   1, 1, 32'h5000,  1,  1, 32'h5000,  4, 0);
        tbl[10] = mkv(1, 16, 32'h16,   0, 0, 0,         1, 10, 32'h10,    4, 0);
        tbl[11] = mkv(1, 15, 32'h15,   0, 0, 0,         1, 11, 32'h11,    3, 1);
        tbl[12] = mkv(0,  0, 0,        0, 0, 0,         1, 12, 32'h12,    3, 1);
        tbl[13] = mkv(0,  0, 0,        0, 0, 0,         1, 13, 32'h13,    2, 1);
        tbl[14] = mkv(0,  0, 0,        0, 0, 0,         1, 15, 32'h15,    1, 1);
        tbl[15] = mkv(0,  0, 0,        0, 0, 0,         0,  0, 0,         0, 1);

        #12;
        chk("rst_rw", RegWrite, 1'b0);
        chk("rst_cnt", Count, 3'd0);
        chk("rst_rdy", EnqReady, 1'b1);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].enq.live, tbl[i].enq.addr, tbl[i].enq.data,
                  tbl[i].pipe_we, tbl[i].pipe_reg, tbl[i].pipe_data);
            chk($sformatf("v%0d_rw", i), RegWrite, tbl[i].exp_rw);
            chk($sformatf("v%0d_wr", i), WriteRegister, tbl[i].exp_wr);
            chk($sformatf("v%0d_wd", i), WriteData, tbl[i].exp_wd);
            chk($sformatf("v%0d_cnt", i), Count, tbl[i].exp_cnt);
            chk($sformatf("v%0d_rdy", i), EnqReady, tbl[i].exp_rdy);
        end
        chk("rf5", rf[5], 32'hA5);
        chk("rf0", rf[0], 32'h0);

        // Pipeline write kills an older buffered entry for the same register.
        drive(1, 7, 32'h11, 0, 0, 0);
        chk_port("kill_a", 0, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 32'h22);
        chk_port("kill_b", 1, 7, 32'h22, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("kill_c", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("kill_d", 0, 0, 0, 0);
        chk("kill_rf7", rf[7], 32'h22);

        // An entry enqueued on the killing edge survives.
        drive(1, 8, 32'h33, 1, 8, 32'h44);
        chk_port("surv_a", 1, 8, 32'h44, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("surv_b", 1, 8, 32'h33, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("surv_c", 0, 0, 0, 0);
        chk("surv_rf8", rf[8], 32'h33);

        // Lookup returns youngest pending entry; $0 and pipe target never hit.
        drive(1, 3, 32'h1, 1, 9, 32'h90);
        drive(1, 3, 32'h2, 1, 9, 32'h91);
        LookupRegister1 = 5'd3; LookupRegister2 = 5'd0;
        drive(0, 0, 0, 1, 9, 32'h92);
        chk("lk_cnt", Count, 3'd2);
        chk("lk_hit1", LookupHit1, BYP);
        chk("lk_data1", LookupData1, BYP ? 32'h2 : 32'h0);
        chk("lk_hit2", LookupHit2, 1'b0);
        chk("lk_data2", LookupData2, 32'h0);
        LookupRegister1 = 5'd9; LookupRegister2 = 5'd3;
        drive(0, 0, 0, 1, 9, 32'h93);
        chk("lk_hit1_pipe", LookupHit1, 1'b0);
        chk("lk_hit2b", LookupHit2, BYP);
        chk("lk_data2b", LookupData2, BYP ? 32'h2 : 32'h0);
        LookupRegister1 = 5'd0; LookupRegister2 = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        chk_port("lk_dr1", 1, 3, 32'h1, 2);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("lk_dr2", 1, 3, 32'h2, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_port("lk_dr3", 0, 0, 0, 0);

        // Short asynchronous reset with three entries pending and pipe active.
        drive(1, 4, 32'h41, 1, 9, 32'h94);
        drive(1, 5, 32'h51, 1, 9, 32'h95);
        drive(1, 6, 32'h61, 1, 9, 32'h96);
        drive(0, 0, 0, 1, 9, 32'h97);
        chk("ar_pre_cnt", Count, 3'd3);
        Rst_n = 1'b0;
        #1;
        chk("ar_cnt", Count, 3'd0);
        chk("ar_rw", RegWrite, 1'b0);
        chk("ar_rdy", EnqReady, 1'b1);
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk_port($sformatf("ar_post%0d", i), 0, 0, 0, 0);
        end
        chk("ar_rf4", rf[4], 32'h0);
        chk("ar_rf6", rf[6], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
